register_unloader_n: RTL and testbench

//  Read-side companion to the n-bit write-enabled register: captures an n-bit word over a

---
 rtl/register_unloader_n.sv | 130 +++++++++++++
 tb/tb_register_unloader_n.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_unloader_n.sv
// -----------------------------------------------------------------------------
// register_unloader_n
//
// Captures an n-bit word over a valid/ready load handshake and streams it out
// bit-serially over a valid/ready serial port. Back-to-back words are supported:
// on the transfer of the last bit the next word can be loaded in the same cycle.
// This means the serial stream has no idle bubble between words.
//
// Parameters
//   n          word width in bits (n >= 1)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit n-1 leaves first
//   CNT_W      bit-index counter width (derived, do not override)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   load_valid  a word is present on d
//   load_ready  the block accepts a word this cycle
//   d           parallel word, sampled only on a load transfer
//   ser_valid   ser_data holds a valid bit
//   ser_ready   the consumer takes the bit this cycle
//   ser_data    current serial bit
//   ser_last    current bit is the final bit of the word
//   busy        a word is in flight
// -----------------------------------------------------------------------------
module register_unloader_n #(
    parameter int n         = 32,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = ($clog2(n) > 0 ? $clog2(n) : 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [n-1:0] d,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_data,
    output logic         ser_last,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

    state_t           state_reg, state_next;
    logic [n-1:0]     shreg_reg, shreg_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [n-1:0]     shreg_shifted;
    logic             at_last;

    assign at_last = (cnt_reg == LAST_CNT);

    // Move the next bit toward the output end; the vacated end fills with 0.
    // For MSB-first the output end is bit n-1, otherwise bit 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_shifted = shreg_reg << 1;
            assign ser_data      = shreg_reg[n-1];
        end else begin : g_lsb_first
            assign shreg_shifted = shreg_reg >> 1;
            assign ser_data      = shreg_reg[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        busy       = 1'b0;

        case (state_reg)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_next = d;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                ser_valid  = 1'b1;
                busy       = 1'b1;
                ser_last   = at_last;
                // The slot frees up exactly when the last bit is being taken,
                // which is what allows a gap-free hand-over to the next word.
                load_ready = at_last & ser_ready;
                if (ser_ready) begin
                    if (!at_last) begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt_reg + 1'b1;
                    end else if (load_valid) begin
                        shreg_next = d;
                        cnt_next   = '0;
                    end else begin
                        // Clear leftovers so the idle output line sits at 0.
                        shreg_next = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_unloader_n.sv
// -----------------------------------------------------------------------------
// Testbench for register_unloader_n. Three instances are exercised:
//   inst0: n=32, LSB first    inst1: n=8, MSB first    inst2: n=1
// A behavioural model (current word + bit position per instance) is checked
// against the DUT on every falling edge, and every completed word received is
// compared with a hand-written table of expected words.
// -----------------------------------------------------------------------------
module tb_register_unloader_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  load_valid, ser_ready;
    logic [2:0]  load_ready, ser_valid, ser_data, ser_last, busy;
    logic [31:0] d_arr [3];

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    bit finished = 1'b0;

    // Hand-computed words every instance must deliver, in order.
    logic [31:0] lit [3][4] = '{
        '{32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'h0000_0001, 32'hA5A5_0F0F},
        '{32'h0000_0081, 32'h0, 32'h0, 32'h0},
        '{32'h1, 32'h0, 32'h1, 32'h0}
    };
    int lit_len [3] = '{4, 1, 3};

    function automatic int n_of(input int i);
        return (i == 0) ? 32 : (i == 1) ? 8 : 1;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 1);
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int NN = (gi == 0) ? 32 : (gi == 1) ? 8 : 1;
            localparam bit MF = (gi == 1);
            register_unloader_n #(.n(NN), .MSB_FIRST(MF)) u_dut (
                .clk        (clk),
                .reset      (reset),
                .load_valid (load_valid[gi]),
                .load_ready (load_ready[gi]),
                .d          (d_arr[gi][NN-1:0]),
                .ser_valid  (ser_valid[gi]),
                .ser_ready  (ser_ready[gi]),
                .ser_data   (ser_data[gi]),
                .ser_last   (ser_last[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %b expected %b at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Model state
    bit          active [3];
    int          idx    [3];
    logic [31:0] cur    [3];
    logic [31:0] rx     [3];
    int          words  [3];

    // Compare process: inputs settle shortly after each rising edge, so at the
    // falling edge both the outputs and the upcoming transfers are known.
    initial begin
        bit ev, el, elr, eb;
        int pos;
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0; idx[i] = 0; cur[i] = '0; rx[i] = '0; words[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    active[i] = 1'b0;
                    idx[i]    = 0;
                    rx[i]     = '0;
                    chk("rst_ser_valid",  i, ser_valid[i],  1'b0);
                    chk("rst_busy",       i, busy[i],       1'b0);
                    chk("rst_load_ready", i, load_ready[i], 1'b1);
                    chk("rst_ser_last",   i, ser_last[i],   1'b0);
                    chk("rst_ser_data",   i, ser_data[i],   1'b0);
                end else begin
                    ev  = active[i];
                    el  = active[i] && (idx[i] == n_of(i) - 1);
                    elr = !active[i] || (el && ser_ready[i]);
                    chk("ser_valid",  i, ser_valid[i],  ev);
                    chk("busy",       i, busy[i],       ev);
                    chk("ser_last",   i, ser_last[i],   el);
                    chk("load_ready", i, load_ready[i], elr);
                    if (active[i]) begin
                        pos = msb_of(i) ? (n_of(i) - 1 - idx[i]) : idx[i];
                        eb  = cur[i][pos];
                        chk("ser_data", i, ser_data[i], eb);
                    end
                    if (active[i] && ser_ready[i]) begin
                        pos = msb_of(i) ? (n_of(i) - 1 - idx[i]) : idx[i];
                        rx[i][pos] = ser_data[i];
                        if (el) begin
                            if (words[i] < lit_len[i]) begin
                                chk_word("rx_word", i, rx[i], lit[i][words[i]]);
                            end else begin
                                chk_word("extra_word", i, rx[i], 32'hxxxx_xxxx);
                            end
                            words[i]++;
                            rx[i]     = '0;
                            active[i] = 1'b0;
                        end else begin
                            idx[i]++;
                        end
                    end
                    if (load_valid[i] && elr) begin
                        cur[i]    = d_arr[i];
                        idx[i]    = 0;
                        active[i] = 1'b1;
                    end
                end
            end
            if (done && !finished) begin
                for (int i = 0; i < 3; i++) begin
                    chk_word("word_count", i, 32'(words[i]), 32'(lit_len[i]));
                end
                finished = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        reset      = 1'b0;
        load_valid = '0;
        ser_ready  = '0;
        for (int i = 0; i < 3; i++) d_arr[i] = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset mid-word: five bits out (cnt=5), then async reset.
        d_arr[0] = 32'h1234_5678; load_valid[0] = 1'b1;
        tick();
        load_valid[0] = 1'b0; ser_ready[0] = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Single word, LSB first, no back-pressure.
        d_arr[0] = 32'hA5A5_0F0F; load_valid[0] = 1'b1;
        tick();
        load_valid[0] = 1'b0; d_arr[0] = 32'hDEAD_BEEF;
        repeat (34) tick();

        // Back-to-back words with load_valid held.
        d_arr[0] = 32'hFFFF_FFFF; load_valid[0] = 1'b1;
        tick();
        d_arr[0] = 32'h0000_0001;
        repeat (32) tick();
        load_valid[0] = 1'b0;
        repeat (34) tick();

        // Back-pressure with ser_ready pattern 1,0,0,1.
        d_arr[0] = 32'hA5A5_0F0F; load_valid[0] = 1'b1; ser_ready[0] = 1'b1;
        tick();
        load_valid[0] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            ser_ready[0] = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
        end
        ser_ready[0] = 1'b1;
        repeat (4) tick();

        // MSB first, n=8.
        ser_ready[1] = 1'b1;
        d_arr[1] = 32'h0000_0081; load_valid[1] = 1'b1;
        tick();
        load_valid[1] = 1'b0;
        repeat (10) tick();

        // n=1 stream 1,0,1 back-to-back.
        ser_ready[2] = 1'b1;
        d_arr[2] = 32'h1; load_valid[2] = 1'b1;
        tick();
        d_arr[2] = 32'h0;
        tick();
        d_arr[2] = 32'h1;
        tick();
        load_valid[2] = 1'b0;
        repeat (3) tick();

        done = 1'b1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
